fft_conj_scale_stream: RTL

- Streaming pre/post-processor that lets the shared FFT core run as either FFT or IFFT, one complex sample per cycle.
- Input path: counts frame position and conjugates samples in IFFT mode, then forwards them to the core.
- Output path: conjugates core results in IFFT mode, divides them by 2^shift with rounding and saturation, tags the frame index and last flag, and reports errors.
- Sits between the subcarrier mapper and the FFT core, and between the core and the cyclic-prefix inserter.

---
 rtl/fft_pkg.sv | 44 ++++
 rtl/cplx_scale_sat.sv | 30 +++
 rtl/fft_conj_scale_stream.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, complex sample type and round/shift/saturate helper
package fft_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_LOG2N = 3;

  localparam logic signed [DEF_DW-1:0] SAT_MAX = {1'b0, {(DEF_DW-1){1'b1}}};
  localparam logic signed [DEF_DW-1:0] SAT_MIN = {1'b1, {(DEF_DW-1){1'b0}}};

  typedef struct packed {
    logic signed [DEF_DW-1:0] re;
    logic signed [DEF_DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_res_t;

  // Wide intermediate keeps the negated most-negative value and the rounding carry exact.
  function automatic sat_res_t sat_round_shift(input logic signed [32:0] value, input int sh,
                                               input int dw, input bit sat_en);
    sat_res_t          r;
    logic signed [32:0] v;
    logic signed [32:0] mx;
    logic signed [32:0] mn;
    v = value;
    if (sh > 0) v = v + (33'sd1 <<< (sh - 1));
    v  = v >>> sh;
    mx = (33'sd1 <<< (dw - 1)) - 33'sd1;
    mn = -(33'sd1 <<< (dw - 1));
    r.sat = 1'b0;
    r.val = v[31:0];
    if (sat_en && (v > mx)) begin
      r.val = mx[31:0];
      r.sat = 1'b1;
    end else if (sat_en && (v < mn)) begin
      r.val = mn[31:0];
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cplx_scale_sat.sv
// rtl/cplx_scale_sat.sv - combinational optional negate, round half-up, shift and saturate
module cplx_scale_sat
  import fft_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int SH_W   = DEF_LOG2N + 1,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [DW-1:0]   din,
  input  logic                   neg,
  input  logic        [SH_W-1:0] sh,
  output logic signed [DW-1:0]   dout,
  output logic                   sat
);

  logic signed [32:0] ext;
  sat_res_t           res;
  logic               unused_hi;

  always_comb begin
    ext = 33'(din);
    if (neg) ext = -ext;
    res  = sat_round_shift(ext, int'(sh), DW, SAT_EN);
    dout = res.val[DW-1:0];
    sat  = res.sat;
  end

  assign unused_hi = ^res.val[31:DW];

endmodule

// File: rtl/fft_conj_scale_stream.sv
// rtl/fft_conj_scale_stream.sv - FFT/IFFT conjugate pre/post stage with output scaling
module fft_conj_scale_stream
  import fft_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int LOG2N  = DEF_LOG2N,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_ifft,
  input  logic [LOG2N:0]       scale_shift,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_re,
  input  logic signed [DW-1:0] s_im,
  input  logic                 s_last,
  output logic                 ci_valid,
  input  logic                 ci_ready,
  output logic signed [DW-1:0] ci_re,
  output logic signed [DW-1:0] ci_im,
  output logic                 ci_last,
  input  logic                 co_valid,
  output logic                 co_ready,
  input  logic signed [DW-1:0] co_re,
  input  logic signed [DW-1:0] co_im,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_re,
  output logic signed [DW-1:0] m_im,
  output logic [LOG2N-1:0]     m_idx,
  output logic                 m_last,
  output logic                 err_frame,
  output logic                 err_sat,
  input  logic                 err_clr
);

  localparam logic [LOG2N-1:0] CNT_LAST = '1;
  localparam logic [LOG2N:0]   SH_MAX   = (LOG2N + 1)'(LOG2N);

  logic [LOG2N-1:0]     in_cnt, out_cnt;
  logic                 in_mode, out_mode;
  logic [LOG2N:0]       out_sh, sh_clamped, sh_cur;
  logic [1:0]           fifo_mem;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;
  logic                 s_acc, co_acc, in_start, out_start, push, pop;
  logic                 mode_in_cur, head_mode, mode_out_cur;
  logic signed [DW-1:0] re_scaled, im_scaled;
  logic                 sat_re, sat_im, frame_bad;

  assign in_start  = (in_cnt == '0);
  assign out_start = (out_cnt == '0);
  // A third frame may not start until the oldest in-flight frame begins leaving.
  assign s_ready   = (!ci_valid || ci_ready) && !(in_start && (fifo_cnt == 2'd2));
  assign co_ready  = !m_valid || m_ready;
  assign s_acc     = s_valid && s_ready;
  assign co_acc    = co_valid && co_ready;
  assign push      = s_acc && in_start;
  assign pop       = co_acc && out_start && (fifo_cnt != 2'd0);

  assign mode_in_cur  = in_start ? mode_ifft : in_mode;
  assign head_mode    = (fifo_cnt != 2'd0) && fifo_mem[rd_ptr];
  assign mode_out_cur = out_start ? head_mode : out_mode;
  assign sh_clamped   = (scale_shift > SH_MAX) ? SH_MAX : scale_shift;
  assign sh_cur       = out_start ? sh_clamped : out_sh;
  assign frame_bad    = s_acc && (s_last != (in_cnt == CNT_LAST));

  cplx_scale_sat #(.DW(DW), .SH_W(LOG2N + 1), .SAT_EN(SAT_EN)) u_re (
    .din(co_re), .neg(1'b0), .sh(sh_cur), .dout(re_scaled), .sat(sat_re)
  );

  cplx_scale_sat #(.DW(DW), .SH_W(LOG2N + 1), .SAT_EN(SAT_EN)) u_im (
    .din(co_im), .neg(mode_out_cur), .sh(sh_cur), .dout(im_scaled), .sat(sat_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_mode   <= 1'b0;
      out_mode  <= 1'b0;
      out_sh    <= '0;
      fifo_mem  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
      ci_valid  <= 1'b0;
      ci_re     <= '0;
      ci_im     <= '0;
      ci_last   <= 1'b0;
      m_valid   <= 1'b0;
      m_re      <= '0;
      m_im      <= '0;
      m_idx     <= '0;
      m_last    <= 1'b0;
      err_frame <= 1'b0;
      err_sat   <= 1'b0;
    end else begin
      if (s_acc) begin
        ci_valid <= 1'b1;
        ci_re    <= s_re;
        ci_im    <= mode_in_cur ? -s_im : s_im;
        ci_last  <= (in_cnt == CNT_LAST);
        in_cnt   <= in_cnt + 1'b1;
        if (in_start) in_mode <= mode_ifft;
      end else if (ci_ready) begin
        ci_valid <= 1'b0;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= mode_ifft;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (co_acc) begin
        m_valid <= 1'b1;
        m_re    <= re_scaled;
        m_im    <= im_scaled;
        m_idx   <= out_cnt;
        m_last  <= (out_cnt == CNT_LAST);
        out_cnt <= out_cnt + 1'b1;
        if (out_start) begin
          out_mode <= head_mode;
          out_sh   <= sh_clamped;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      // A fresh error in the clearing cycle wins over the clear.
      if (err_clr) err_frame <= 1'b0;
      if (frame_bad) err_frame <= 1'b1;
      if (err_clr) err_sat <= 1'b0;
      if (co_acc && (sat_re || sat_im)) err_sat <= 1'b1;
    end
  end

endmodule
